// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FWFT FIFO.
// Provides default WIDTH/DEPTH values and ptr_width(), the pointer width
// (one extra bit over the address so full and empty can be told apart).
package fifo_pkg;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned DEPTH_DEF = 16;

    // Address bits plus one wrap bit; also the width of the entry count.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft_if.sv
// Handshake bundle for sync_fifo_fwft.
// master : producer/consumer side (drives wr_i, wr_data_i, rd_i)
// slave  : FIFO side (drives rd_data_o, full_o, empty_o, afull_o, aempty_o, count_o)
// Optional macro SYNC_FIFO_ERR_EN adds err_clr_i, overflow_o, underflow_o.
interface sync_fifo_fwft_if
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
);

    localparam int unsigned CNT_W = ptr_width(DEPTH);

    logic             wr_i;
    logic [WIDTH-1:0] wr_data_i;
    logic             rd_i;
    logic [WIDTH-1:0] rd_data_o;
    logic             full_o;
    logic             empty_o;
    logic             afull_o;
    logic             aempty_o;
    logic [CNT_W-1:0] count_o;
`ifdef SYNC_FIFO_ERR_EN
    logic             err_clr_i;
    logic             overflow_o;
    logic             underflow_o;
`endif

`ifdef SYNC_FIFO_ERR_EN
    modport master (
        output wr_i, wr_data_i, rd_i, err_clr_i,
        input  rd_data_o, full_o, empty_o, afull_o, aempty_o, count_o,
               overflow_o, underflow_o
    );
    modport slave (
        input  wr_i, wr_data_i, rd_i, err_clr_i,
        output rd_data_o, full_o, empty_o, afull_o, aempty_o, count_o,
               overflow_o, underflow_o
    );
`else
    modport master (
        output wr_i, wr_data_i, rd_i,
        input  rd_data_o, full_o, empty_o, afull_o, aempty_o, count_o
    );
    modport slave (
        input  wr_i, wr_data_i, rd_i,
        output rd_data_o, full_o, empty_o, afull_o, aempty_o, count_o
    );
`endif

endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port storage for the FIFO: synchronous write, asynchronous read.
// Ports: clk_i, wr_en_i/wr_addr_i/wr_data_i (write port),
//        rd_addr_i -> rd_data_c (combinational read port).
// Contents are not reset; the owner tracks which entries are valid.
module fifo_ram #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 16,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0]  rd_data_c
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    // Read port: head word is visible without latency
    assign rd_data_c = mem[rd_addr_i];

endmodule

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO.
// Ports: clk_i (rising edge), reset_ni (async, active-low),
//        bus (sync_fifo_fwft_if.slave): write/pop handshake, head data,
//        full/empty/almost-full/almost-empty flags and entry count.
// Optional macro SYNC_FIFO_ERR_EN adds sticky overflow/underflow flags
// cleared by err_clr_i.
// Pointers carry one wrap bit; count = wr_ptr - rd_ptr, and every flag is
// decoded from the registered pointers only.
module sync_fifo_fwft
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = WIDTH_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF,
    parameter int unsigned AFULL_TH  = DEPTH - 2,
    parameter int unsigned AEMPTY_TH = 2
) (
    input  logic clk_i,
    input  logic reset_ni,
    sync_fifo_fwft_if.slave bus
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned PTR_W  = ptr_width(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] count_c;
    logic             empty_c;
    logic             full_c;
    logic             wr_en_c;
    logic             rd_en_c;
    logic [WIDTH-1:0] head_c;

    // Status decode from registered pointers
    always_comb begin
        count_c = wr_ptr - rd_ptr;
        empty_c = (count_c == '0);
        full_c  = (count_c == PTR_W'(DEPTH));
    end

    // A full FIFO still takes a write when the head is popped in the same cycle
    always_comb begin
        rd_en_c = bus.rd_i && !empty_c;
        wr_en_c = bus.wr_i && (!full_c || bus.rd_i);
    end

    // Pointer registers
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i     (clk_i),
        .wr_en_i   (wr_en_c),
        .wr_addr_i (wr_ptr[ADDR_W-1:0]),
        .wr_data_i (bus.wr_data_i),
        .rd_addr_i (rd_ptr[ADDR_W-1:0]),
        .rd_data_c (head_c)
    );

    // Stale RAM contents are masked so an empty FIFO always presents zero
    assign bus.rd_data_o = empty_c ? '0 : head_c;
    assign bus.empty_o   = empty_c;
    assign bus.full_o    = full_c;
    assign bus.afull_o   = (count_c >= PTR_W'(AFULL_TH));
    assign bus.aempty_o  = (count_c <= PTR_W'(AEMPTY_TH));
    assign bus.count_o   = count_c;

`ifdef SYNC_FIFO_ERR_EN
    logic overflow_q;
    logic underflow_q;
    logic ovf_set_c;
    logic unf_set_c;

    always_comb begin
        ovf_set_c = bus.wr_i && full_c && !bus.rd_i;
        unf_set_c = bus.rd_i && empty_c;
    end

    // Sticky error flags; a new event outranks a clear in the same cycle
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (ovf_set_c) begin
                overflow_q <= 1'b1;
            end else if (bus.err_clr_i) begin
                overflow_q <= 1'b0;
            end
            if (unf_set_c) begin
                underflow_q <= 1'b1;
            end else if (bus.err_clr_i) begin
                underflow_q <= 1'b0;
            end
        end
    end

    assign bus.overflow_o  = overflow_q;
    assign bus.underflow_o = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Self-checking bench for sync_fifo_fwft (WIDTH=8, DEPTH=4, AFULL_TH=3,
// AEMPTY_TH=1) against a queue-based reference model.
module tb_sync_fifo_fwft;

    localparam int unsigned W   = 8;
    localparam int unsigned D   = 4;
    localparam int unsigned AF  = 3;
    localparam int unsigned AE  = 1;

    logic clk;
    logic rst_n;

    int checks;
    int errors;

    // Reference model
    logic [W-1:0] q[$];
    logic         m_ovf;
    logic         m_unf;

    sync_fifo_fwft_if #(.WIDTH(W), .DEPTH(D)) bus ();

    sync_fifo_fwft #(
        .WIDTH     (W),
        .DEPTH     (D),
        .AFULL_TH  (AF),
        .AEMPTY_TH (AE)
    ) dut (
        .clk_i    (clk),
        .reset_ni (rst_n),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] m_head();
        logic [W-1:0] h;
        h = '0;
        if (q.size() != 0) h = q[0];
        return h;
    endfunction

    // One clock of stimulus; updates the model from the FIFO rules
    task automatic step(input logic wr, input logic [W-1:0] d, input logic rd, input logic clr);
        int unsigned sz;
        @(negedge clk);
        bus.wr_i      = wr;
        bus.wr_data_i = d;
        bus.rd_i      = rd;
`ifdef SYNC_FIFO_ERR_EN
        bus.err_clr_i = clr;
`endif
        @(posedge clk);
        sz = q.size();
        if (wr && sz == D && !rd) m_ovf = 1'b1;
        else if (clr)             m_ovf = 1'b0;
        if (rd && sz == 0)        m_unf = 1'b1;
        else if (clr)             m_unf = 1'b0;
        if (rd && sz > 0) void'(q.pop_front());
        if (wr && (sz < D || rd)) q.push_back(d);
        #1;
        bus.wr_i = 1'b0;
        bus.rd_i = 1'b0;
`ifdef SYNC_FIFO_ERR_EN
        bus.err_clr_i = 1'b0;
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.wr_i = 1'b0; bus.rd_i = 1'b0; bus.wr_data_i = '0;
`ifdef SYNC_FIFO_ERR_EN
        bus.err_clr_i = 1'b0;
`endif
        q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        #1;
        checks++; if (bus.count_o !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", bus.count_o); end
        checks++; if (bus.empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b exp 1", bus.empty_o); end
        checks++; if (bus.aempty_o !== 1'b1) begin errors++; $display("FAIL reset_aempty: got %b exp 1", bus.aempty_o); end
        checks++; if (bus.full_o !== 1'b0) begin errors++; $display("FAIL reset_full: got %b exp 0", bus.full_o); end
        checks++; if (bus.afull_o !== 1'b0) begin errors++; $display("FAIL reset_afull: got %b exp 0", bus.afull_o); end
        checks++; if (bus.rd_data_o !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h exp 00", bus.rd_data_o); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (bus.empty_o !== 1'b1 || bus.rd_data_o !== 8'h00) begin
            errors++; $display("FAIL post_reset: empty %b data %h exp 1 00", bus.empty_o, bus.rd_data_o);
        end
    endtask

    task automatic test_first_word();
        step(1'b1, 8'hA1, 1'b0, 1'b0);
        checks++; if (bus.empty_o !== 1'b0) begin errors++; $display("FAIL fw_empty: got %b exp 0", bus.empty_o); end
        checks++; if (bus.rd_data_o !== 8'hA1) begin errors++; $display("FAIL fw_data: got %h exp a1", bus.rd_data_o); end
        checks++; if (bus.count_o !== 3'd1) begin errors++; $display("FAIL fw_count: got %0d exp 1", bus.count_o); end
        checks++; if (bus.aempty_o !== 1'b1) begin errors++; $display("FAIL fw_aempty: got %b exp 1", bus.aempty_o); end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (bus.empty_o !== 1'b1 || bus.count_o !== 3'd0) begin
            errors++; $display("FAIL fw_drain: empty %b count %0d exp 1 0", bus.empty_o, bus.count_o);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            checks++; if (bus.count_o !== 3'(q.size()) || bus.afull_o !== (q.size() >= AF) || bus.aempty_o !== (q.size() <= AE)) begin
                errors++; $display("FAIL fill_%0d: count %0d af %b ae %b exp %0d", i, bus.count_o, bus.afull_o, bus.aempty_o, q.size());
            end
        end
        checks++; if (bus.full_o !== 1'b1) begin errors++; $display("FAIL fill_full: got %b exp 1", bus.full_o); end
        checks++; if (bus.afull_o !== 1'b1) begin errors++; $display("FAIL fill_afull: got %b exp 1", bus.afull_o); end
        checks++; if (bus.count_o !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d exp 4", bus.count_o); end
        step(1'b1, 8'h05, 1'b0, 1'b0);
        checks++; if (bus.count_o !== 3'd4 || bus.rd_data_o !== 8'h01) begin
            errors++; $display("FAIL drop_write: count %0d data %h exp 4 01", bus.count_o, bus.rd_data_o);
        end
`ifdef SYNC_FIFO_ERR_EN
        checks++; if (bus.overflow_o !== 1'b1) begin errors++; $display("FAIL overflow_set: got %b exp 1", bus.overflow_o); end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (bus.overflow_o !== 1'b0) begin errors++; $display("FAIL overflow_clr: got %b exp 0", bus.overflow_o); end
`endif
    endtask

    task automatic test_full_rw();
        logic [W-1:0] exp_seq [4];
        exp_seq[0] = 8'h02; exp_seq[1] = 8'h03; exp_seq[2] = 8'h04; exp_seq[3] = 8'h05;
        step(1'b1, 8'h05, 1'b1, 1'b0);
        checks++; if (bus.count_o !== 3'd4 || bus.full_o !== 1'b1) begin
            errors++; $display("FAIL full_rw_count: count %0d full %b exp 4 1", bus.count_o, bus.full_o);
        end
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.rd_data_o !== exp_seq[i]) begin
                errors++; $display("FAIL full_rw_pop%0d: got %h exp %h", i, bus.rd_data_o, exp_seq[i]);
            end
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        checks++; if (bus.empty_o !== 1'b1 || bus.count_o !== 3'd0) begin
            errors++; $display("FAIL full_rw_drain: empty %b count %0d exp 1 0", bus.empty_o, bus.count_o);
        end
    endtask

    task automatic test_underflow();
        step(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (bus.count_o !== 3'd0 || bus.empty_o !== 1'b1 || bus.rd_data_o !== 8'h00) begin
            errors++; $display("FAIL underflow_state: count %0d empty %b data %h exp 0 1 00", bus.count_o, bus.empty_o, bus.rd_data_o);
        end
`ifdef SYNC_FIFO_ERR_EN
        checks++; if (bus.underflow_o !== 1'b1) begin errors++; $display("FAIL underflow_set: got %b exp 1", bus.underflow_o); end
        // set outranks clear in the same cycle
        step(1'b0, 8'h00, 1'b1, 1'b1);
        checks++; if (bus.underflow_o !== 1'b1) begin errors++; $display("FAIL underflow_set_wins: got %b exp 1", bus.underflow_o); end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (bus.underflow_o !== 1'b0) begin errors++; $display("FAIL underflow_clr: got %b exp 0", bus.underflow_o); end
`endif
    endtask

    task automatic test_wrap();
        logic [W-1:0] d;
        for (int i = 0; i < 10; i++) begin
            d = 8'(8'h30 + i);
            step(1'b1, d, 1'b0, 1'b0);
            checks++; if (bus.rd_data_o !== d || bus.count_o !== 3'd1 || bus.empty_o !== 1'b0 || bus.full_o !== 1'b0 || bus.afull_o !== 1'b0 || bus.aempty_o !== 1'b1) begin
                errors++; $display("FAIL wrap_wr%0d: data %h cnt %0d e%b f%b af%b ae%b exp %h 1", i, bus.rd_data_o, bus.count_o, bus.empty_o, bus.full_o, bus.afull_o, bus.aempty_o, d);
            end
            step(1'b0, 8'h00, 1'b1, 1'b0);
            checks++; if (bus.count_o !== 3'd0 || bus.empty_o !== 1'b1 || bus.aempty_o !== 1'b1 || bus.afull_o !== 1'b0) begin
                errors++; $display("FAIL wrap_rd%0d: cnt %0d e%b ae%b af%b", i, bus.count_o, bus.empty_o, bus.aempty_o, bus.afull_o);
            end
        end
    endtask

    task automatic test_random();
        logic         wr;
        logic         rd;
        logic         clr;
        logic [W-1:0] d;
        for (int i = 0; i < 400; i++) begin
            wr  = ($urandom_range(0, 99) < 55);
            rd  = ($urandom_range(0, 99) < 45);
            clr = ($urandom_range(0, 99) < 5);
            d   = 8'($urandom_range(0, 255));
            step(wr, d, rd, clr);
            checks++; if (bus.count_o !== 3'(q.size())) begin errors++; $display("FAIL rand_count[%0d]: got %0d exp %0d", i, bus.count_o, q.size()); end
            checks++; if (bus.rd_data_o !== m_head()) begin errors++; $display("FAIL rand_data[%0d]: got %h exp %h", i, bus.rd_data_o, m_head()); end
            checks++; if (bus.empty_o !== (q.size() == 0) || bus.full_o !== (q.size() == D)) begin
                errors++; $display("FAIL rand_ef[%0d]: e%b f%b size %0d", i, bus.empty_o, bus.full_o, q.size());
            end
            checks++; if (bus.afull_o !== (q.size() >= AF) || bus.aempty_o !== (q.size() <= AE)) begin
                errors++; $display("FAIL rand_almost[%0d]: af%b ae%b size %0d", i, bus.afull_o, bus.aempty_o, q.size());
            end
`ifdef SYNC_FIFO_ERR_EN
            checks++; if (bus.overflow_o !== m_ovf || bus.underflow_o !== m_unf) begin
                errors++; $display("FAIL rand_err[%0d]: ovf %b unf %b exp %b %b", i, bus.overflow_o, bus.underflow_o, m_ovf, m_unf);
            end
`endif
        end
    endtask

    task automatic test_async_reset();
        // drain whatever the random phase left behind
        while (q.size() != 0) step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        checks++; if (bus.count_o !== 3'd3) begin errors++; $display("FAIL arst_pre_count: got %0d exp 3", bus.count_o); end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        checks++; if (bus.count_o !== 3'd0 || bus.empty_o !== 1'b1) begin
            errors++; $display("FAIL arst_count: count %0d empty %b exp 0 1", bus.count_o, bus.empty_o);
        end
        checks++; if (bus.aempty_o !== 1'b1 || bus.afull_o !== 1'b0 || bus.full_o !== 1'b0 || bus.rd_data_o !== 8'h00) begin
            errors++; $display("FAIL arst_flags: ae%b af%b f%b data %h exp 1 0 0 00", bus.aempty_o, bus.afull_o, bus.full_o, bus.rd_data_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        checks++; if (bus.count_o !== 3'd1 || bus.rd_data_o !== 8'h5A) begin
            errors++; $display("FAIL arst_after: count %0d data %h exp 1 5a", bus.count_o, bus.rd_data_o);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_first_word();
        test_fill_overflow();
        test_full_rw();
        test_underflow();
        test_wrap();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sync_fifo_fwft.md
SYNC_FIFO_FWFT -- requirements
Module: sync_fifo_fwft

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, entry count; power of two, >= 2.
REQ-003 SHALL have parameter AFULL_TH, default DEPTH-2, almost-full threshold in entries.
REQ-004 SHALL have parameter AEMPTY_TH, default 2, almost-empty threshold in entries.
REQ-005 SHALL have port clk_i  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port reset_ni  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port wr_i  input  1  write request.
REQ-008 SHALL have port wr_data_i  input  WIDTH  write data.
REQ-009 SHALL have port rd_i  input  1  pop request; acknowledges the current head word.
REQ-010 SHALL have port rd_data_o  output  WIDTH  head word; valid whenever empty_o=0.
REQ-011 SHALL have ports full_o, empty_o, afull_o, aempty_o  output  1 each  status flags.
REQ-012 SHALL have port count_o  output  $clog2(DEPTH)+1  number of stored entries.

Function
REQ-013 SHALL operate first-word-fall-through: head word is on rd_data_o with no read latency.
REQ-014 SHALL make a word written at edge N into an empty FIFO visible on rd_data_o, with empty_o=0, after edge N.
REQ-015 SHALL accept a write when wr_i=1 and (full_o=0 or rd_i=1).
REQ-016 SHALL pop when rd_i=1 and empty_o=0; rd_i while empty SHALL be ignored with no state change.
REQ-017 SHALL, on simultaneous accepted write and pop, leave count_o unchanged and preserve word order.
REQ-018 SHALL, on wr_i while full with rd_i=0, drop the write and leave contents unchanged.
REQ-019 SHALL keep count_o in 0..DEPTH; empty_o = (count_o==0); full_o = (count_o==DEPTH).
REQ-020 SHALL drive afull_o = (count_o >= AFULL_TH) and aempty_o = (count_o <= AEMPTY_TH).
REQ-021 SHALL keep all flags and count_o registered (combinationally derived only from registered state).
REQ-022 SHALL use DEPTH_BITS+1-bit read/write pointers wrapping modulo 2*DEPTH; count = wrp-rdp.

Reset
REQ-023 SHALL, while reset_ni=0, asynchronously clear pointers and count_o to 0.
REQ-024 SHALL, during and after reset, drive empty_o=1, aempty_o=1, full_o=0, afull_o=0 and rd_data_o=0.
REQ-025 SHALL treat reset asserted mid-operation as discarding all stored words; memory contents need no clearing.

Configuration
REQ-026 SHALL recognise macro SYNC_FIFO_ERR_EN.
REQ-027 SHALL, with SYNC_FIFO_ERR_EN defined, add input err_clr_i and outputs overflow_o, underflow_o (1 bit each).
REQ-028 SHALL set overflow_o sticky on a dropped write (REQ-018) and underflow_o sticky on rd_i while empty.
REQ-029 SHALL clear both sticky flags on err_clr_i=1 or reset; a same-cycle set SHALL win over err_clr_i.
REQ-030 SHALL, without SYNC_FIFO_ERR_EN, omit those ports and logic entirely; all other behaviour SHALL be identical.

Structure
REQ-031 SHALL place a ptr_width(depth) function and the WIDTH/DEPTH default constants in package fifo_pkg.
REQ-032 SHALL place storage in sub-module fifo_ram: simple dual-port, synchronous write, asynchronous read.
REQ-033 SHALL keep pointers, count and flag logic in sync_fifo_fwft.

Verification (WIDTH=8, DEPTH=4, AFULL_TH=3, AEMPTY_TH=1)
REQ-034 SHALL cover this scenario: reset, write 0xA1 -> next cycle empty_o=0, rd_data_o=0xA1, count_o=1, aempty_o=1.
REQ-035 SHALL cover this scenario: write 0x01..0x04 -> full_o=1, afull_o=1, count_o=4; then write 0x05 with rd_i=0 -> dropped, overflow_o=1 (ERR_EN).
REQ-036 SHALL cover this scenario: when full, wr_i=1, rd_i=1 with 0x05 -> 0x01 popped, count_o stays 4, pops then yield 0x02,0x03,0x04,0x05.
REQ-037 SHALL cover this scenario: rd_i=1 on empty FIFO -> no change, count_o=0, underflow_o=1; err_clr_i -> underflow_o=0.
REQ-038 SHALL cover this scenario: 10 write/pop pairs across pointer wrap -> output order matches input, no flag glitches.
REQ-039 SHALL cover this scenario: reset_ni low asynchronously with count_o=3 -> count_o=0, empty_o=1 before next clock edge.
